// File: rtl/apb_pkg.sv
// Shared definitions for the APB master arbiter: FSM state encoding and
// default bus widths.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after
// ptr, wrapping around, and returns it as a one-hot grant.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic             found;
    logic [IDX_W-1:0] sel;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sel = IDX_W'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[sel]) begin
                grant[sel] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by NUM_REQ requesters: round-robin grant, registered
// IDLE/SETUP/ACCESS sequencing, and an ACCESS-phase timeout.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      psel,
    output logic                      penable,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    apb_state_t         state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   cur;
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W-1:0]   ptr_next;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic               sel_write;
    logic               done;
    logic               start;

    // Mask any requester whose response is still owed (current transfer or
    // the rsp_valid pulse going out this cycle) so it cannot be re-granted.
    always_comb begin
        arb_req = req_valid & ~rsp_valid;
        if (state == ACCESS) arb_req[cur] = 1'b0;
    end

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_rr (
        .req  (arb_req),
        .ptr  (ptr),
        .grant(arb_grant)
    );

    always_comb begin
        arb_idx   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                arb_idx   = IDX_W'(i);
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_write = req_write[i];
            end
        end
    end

    assign ptr_next = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
    assign done     = (state == ACCESS) && (pready || (cnt == CNT_W'(TIMEOUT)));
    assign start    = (|arb_grant) && ((state == IDLE) || done);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            req_ack     <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            ptr         <= '0;
            cur         <= '0;
            cnt         <= '0;
        end else begin
            req_ack     <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            case (state)
                SETUP: begin
                    penable <= 1'b1;
                    cnt     <= CNT_W'(1);
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        rsp_valid[cur] <= 1'b1;
                        rsp_rdata      <= (pready && !pwrite) ? prdata : '0;
                        rsp_err        <= pslverr || !pready;
                        rsp_timeout    <= !pready;
                        psel           <= 1'b0;
                        penable        <= 1'b0;
                        cnt            <= '0;
                        state          <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // A new grant overrides the IDLE fall-back above, giving
            // back-to-back SETUP with psel held high.
            if (start) begin
                req_ack <= arb_grant;
                cur     <= arb_idx;
                ptr     <= ptr_next;
                paddr   <= sel_addr;
                pwrite  <= sel_write;
                pwdata  <= sel_wdata;
                psel    <= 1'b1;
                penable <= 1'b0;
                state   <= SETUP;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: vector table of single transfers
// plus sequences for fairness, re-grant masking, timeout hand-off and reset.
module tb_apb_master_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [NR-1:0]    req_valid, req_write, req_ack, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [DW-1:0]    rsp_rdata, pwdata, prdata;
    logic [AW-1:0]    paddr;
    logic             rsp_err, rsp_timeout, psel, penable, pwrite, pready, pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_ack(req_ack), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned req;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        int unsigned waits;
        logic        slverr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int unsigned exp_lat;
        int unsigned exp_pen;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [NR-1:0] onehot(input int unsigned i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int unsigned idx_of(input logic [NR-1:0] v);
        int unsigned r;
        r = 99;
        for (int unsigned i = 0; i < NR; i++) if (v[i]) r = i;
        return r;
    endfunction

    function automatic logic zero_or_onehot(input logic [NR-1:0] v);
        return (v & (v - 1'b1)) == '0;
    endfunction

    task automatic set_req(input int unsigned i, input logic wr, input logic [31:0] a, input logic [31:0] d);
        req_valid[i]         = 1'b1;
        req_write[i]         = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        pready    = 1'b0;
        pslverr   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[5];
        vec_t        v;
        int unsigned n, pen, cnt_a, cnt_b;
        logic        stable;
        int unsigned order[$];

        vecs[0] = '{0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0,  1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 3,  1};
        vecs[1] = '{1, 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 32'h1234_5678, 3, 1'b0, 32'h0, 1'b0, 1'b0, 6, 4};
        vecs[2] = '{2, 1'b0, 32'h0000_0030, 32'h5555_0000, 32'hCAFE_F00D, 1, 1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 4, 2};
        vecs[3] = '{3, 1'b0, 32'h0000_0040, 32'h0, 32'h7777_7777, 99, 1'b0, 32'h0, 1'b1, 1'b1, 18, 16};
        vecs[4] = '{0, 1'b1, 32'h0000_0050, 32'h0F0F_0F0F, 32'h8888_8888, 0, 1'b1, 32'h0, 1'b1, 1'b0, 3, 1};

        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        do_reset();
        reset = 1'b1;
        check("reset_apb", {psel, penable, pwrite, paddr, pwdata[30:0]}, '0);
        check("reset_rsp", {req_ack, rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, '0);
        reset = 1'b0;

        for (int k = 0; k < 5; k++) begin
            v = vecs[k];
            set_req(v.req, v.wr, v.addr, v.wdata);
            pready  = 1'b1;   // must be ignored in IDLE and SETUP
            pslverr = 1'b1;
            tick();
            check($sformatf("v%0d_ack", k), req_ack, onehot(v.req));
            check($sformatf("v%0d_setup", k), {psel, penable, pwrite, paddr}, {1'b1, 1'b0, v.wr, v.addr});
            req_valid = '0;
            tick();
            n = 2; pen = 0; stable = 1'b1;
            while (n < 40) begin
                if (penable) begin
                    pen++;
                    if (paddr !== v.addr || pwdata !== v.wdata || pwrite !== v.wr) stable = 1'b0;
                end
                if (n == 2 + v.waits) begin
                    pready = 1'b1; pslverr = v.slverr; prdata = v.prdata;
                end else begin
                    pready = 1'b0; pslverr = 1'b1; prdata = 32'hBAD0_BAD0;
                end
                tick();
                n++;
                if (rsp_valid != '0) break;
            end
            check($sformatf("v%0d_latency", k), 64'(n), 64'(v.exp_lat));
            check($sformatf("v%0d_rsp_valid", k), rsp_valid, onehot(v.req));
            check($sformatf("v%0d_rdata", k), rsp_rdata, v.exp_rdata);
            check($sformatf("v%0d_err_to", k), {rsp_err, rsp_timeout}, {v.exp_err, v.exp_to});
            check($sformatf("v%0d_penable_cycles", k), 64'(pen), 64'(v.exp_pen));
            check($sformatf("v%0d_stable", k), stable, 1'b1);
            check($sformatf("v%0d_idle_psel", k), {psel, penable}, 2'b00);
            pready = 1'b0;
            tick();
            check($sformatf("v%0d_rsp_pulse", k), rsp_valid, '0);
        end

        // Fairness: all four continuously requesting, slave always ready.
        do_reset();
        for (int unsigned i = 0; i < NR; i++) set_req(i, 1'b0, 32'h100 + 32'(i) * 4, 32'h0);
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h0;
        cnt_a = 0; cnt_b = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (req_ack != '0) order.push_back(idx_of(req_ack));
            if (!psel) cnt_a++;
            if (!zero_or_onehot(req_ack) || !zero_or_onehot(rsp_valid)) cnt_b++;
            if (c == 3) check("fair_ack_and_rsp", {req_ack, rsp_valid}, {4'b0010, 4'b0001});
            if (c == 5) check("fair_paddr2", paddr, 32'h108);
        end
        check("fair_grants", 64'(order.size()), 64'd5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            check($sformatf("fair_order%0d", i), 64'(order[i]), 64'(i % 4));
        check("fair_psel_drops", 64'(cnt_a), 64'd0);
        check("fair_onehot", 64'(cnt_b), 64'd0);
        req_valid = '0;
        tick(); tick(); tick();
        check("fair_end_idle", psel, 1'b0);

        // A lone requester must not be re-granted while its rsp_valid is out.
        do_reset();
        set_req(0, 1'b0, 32'h200, 32'h0);
        pready = 1'b1;
        tick();
        check("regrant_ack1", req_ack, 4'b0001);
        tick();
        tick();
        check("regrant_c3", {rsp_valid, req_ack, psel}, {4'b0001, 4'b0000, 1'b0});
        tick();
        check("regrant_c4", req_ack, 4'b0000);
        tick();
        check("regrant_c5", {req_ack, psel}, {4'b0001, 1'b1});
        req_valid = '0;
        tick(); tick(); tick();

        // Timeout, then the pending requester proceeds without an IDLE cycle.
        do_reset();
        set_req(0, 1'b0, 32'h40, 32'h0);
        pready = 1'b0; pslverr = 1'b0;
        tick();
        check("to_ack0", req_ack, 4'b0001);
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 32'h44, 32'h1111_2222);
        pen = 0; cnt_a = 0;
        for (int c = 2; c <= 17; c++) begin
            tick();
            if (penable) pen++;
            if (rsp_valid != '0) cnt_a++;
        end
        check("to_penable_cycles", 64'(pen), 64'd16);
        check("to_no_early_rsp", 64'(cnt_a), 64'd0);
        tick();
        check("to_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {4'b0001, 1'b1, 1'b1, 32'h0});
        check("to_next_setup", {req_ack, psel, penable, pwrite, paddr}, {4'b0010, 1'b1, 1'b0, 1'b1, 32'h44});
        req_valid = '0;
        pready = 1'b1; prdata = 32'h600D_600D;
        tick();
        tick();
        check("to_next_rsp", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}, {4'b0010, 1'b0, 1'b0, 32'h0});

        // Reset during ACCESS abandons the transfer and rewinds the pointer.
        tick();
        set_req(2, 1'b0, 32'h80, 32'h0);
        pready = 1'b0;
        tick();
        check("rst_ack2", req_ack, 4'b0100);
        req_valid = '0;
        tick();
        tick();
        check("rst_in_access", {psel, penable}, 2'b11);
        reset = 1'b1;
        tick();
        check("rst_abandon", {psel, penable, rsp_valid}, {1'b0, 1'b0, 4'b0000});
        reset = 1'b0;
        pready = 1'b1;
        cnt_a = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (rsp_valid != '0) cnt_a++;
        end
        check("rst_no_rsp", 64'(cnt_a), 64'd0);
        set_req(1, 1'b0, 32'h90, 32'h0);
        set_req(3, 1'b0, 32'h98, 32'h0);
        tick();
        check("rst_ptr_zero", req_ack, 4'b0010);
        req_valid = '0;
        tick(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
